// File: rtl/collatz_sweep_ctrl.sv
// Sweeps a contiguous range of start values through an external Collatz step unit.
// Optional COLLATZ_TOTAL_STEPS_EN builds a saturating 48-bit step accumulator.
module collatz_sweep_ctrl #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned CNT_BITS  = 16,
  parameter int unsigned LEN_BITS  = 16,
  parameter int unsigned MAX_STEPS = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITS-1:0]     base,
  input  logic [CNT_BITS-1:0] count,
  output logic [BITS-1:0]     step_iter,
  input  logic [BITS-1:0]     step_next,
  input  logic                step_ovf,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [LEN_BITS-1:0] best_len,
  output logic [BITS-1:0]     best_len_num,
  output logic [BITS-1:0]     best_peak,
  output logic [BITS-1:0]     best_peak_num,
  output logic [CNT_BITS-1:0] fail_count,
  output logic [47:0]         total_steps
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_RECORD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [BITS-1:0]     cur_num_q, cur_num_d;
  logic [CNT_BITS-1:0] remaining_q, remaining_d;
  logic [BITS-1:0]     iter_q, iter_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [BITS-1:0]     peak_q, peak_d;
  logic                ok_q, ok_d;
  logic [LEN_BITS-1:0] best_len_q, best_len_d;
  logic [BITS-1:0]     best_len_num_q, best_len_num_d;
  logic [BITS-1:0]     best_peak_q, best_peak_d;
  logic [BITS-1:0]     best_peak_num_q, best_peak_num_d;
  logic [CNT_BITS-1:0] fail_count_q, fail_count_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ts_inc, ts_clr;

  // State register and all sequencer/result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cur_num_q       <= '0;
      remaining_q     <= '0;
      iter_q          <= '0;
      len_q           <= '0;
      peak_q          <= '0;
      ok_q            <= 1'b0;
      best_len_q      <= '0;
      best_len_num_q  <= '0;
      best_peak_q     <= '0;
      best_peak_num_q <= '0;
      fail_count_q    <= '0;
      aborted_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_num_q       <= cur_num_d;
      remaining_q     <= remaining_d;
      iter_q          <= iter_d;
      len_q           <= len_d;
      peak_q          <= peak_d;
      ok_q            <= ok_d;
      best_len_q      <= best_len_d;
      best_len_num_q  <= best_len_num_d;
      best_peak_q     <= best_peak_d;
      best_peak_num_q <= best_peak_num_d;
      fail_count_q    <= fail_count_d;
      aborted_q       <= aborted_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d         = state_q;
    cur_num_d       = cur_num_q;
    remaining_d     = remaining_q;
    iter_d          = iter_q;
    len_d           = len_q;
    peak_d          = peak_q;
    ok_d            = ok_q;
    best_len_d      = best_len_q;
    best_len_num_d  = best_len_num_q;
    best_peak_d     = best_peak_q;
    best_peak_num_d = best_peak_num_q;
    fail_count_d    = fail_count_q;
    aborted_d       = aborted_q;
    ts_inc          = 1'b0;
    ts_clr          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_num_d       = base;
          remaining_d     = count;
          best_len_d      = '0;
          best_len_num_d  = '0;
          best_peak_d     = '0;
          best_peak_num_d = '0;
          fail_count_d    = '0;
          aborted_d       = 1'b0;
          ts_clr          = 1'b1;
          state_d         = (count == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          iter_d  = cur_num_q;
          len_d   = '0;
          peak_d  = cur_num_q;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (iter_q == BITS'(1)) begin
          ok_d    = 1'b1;
          state_d = S_RECORD;
        end else if ((iter_q == '0) || step_ovf || (len_q == LEN_BITS'(MAX_STEPS))) begin
          ok_d    = 1'b0;
          state_d = S_RECORD;
        end else begin
          iter_d = step_next;
          len_d  = len_q + LEN_BITS'(1);
          peak_d = (step_next > peak_q) ? step_next : peak_q;
          ts_inc = 1'b1;
        end
      end

      S_RECORD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          // Strict compares keep the earlier start value on ties
          if (ok_q) begin
            if (len_q > best_len_q) begin
              best_len_d     = len_q;
              best_len_num_d = cur_num_q;
            end
            if (peak_q > best_peak_q) begin
              best_peak_d     = peak_q;
              best_peak_num_d = cur_num_q;
            end
          end else begin
            fail_count_d = fail_count_q + CNT_BITS'(1);
          end

          if (remaining_q == CNT_BITS'(1)) begin
            state_d = S_DONE;
          end else if (cur_num_q == '1) begin
            aborted_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cur_num_d   = cur_num_q + BITS'(1);
            remaining_d = remaining_q - CNT_BITS'(1);
            state_d     = S_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_RECORD);
    done_d = (state_d == S_DONE);
  end

`ifdef COLLATZ_TOTAL_STEPS_EN
  logic [47:0] total_q;

  // Saturating count of every RUN step across the sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (ts_clr) begin
      total_q <= '0;
    end else if (ts_inc && (total_q != '1)) begin
      total_q <= total_q + 48'd1;
    end
  end

  assign total_steps = total_q;
`else
  logic unused_ts;
  assign unused_ts   = ts_inc ^ ts_clr;
  assign total_steps = '0;
`endif

  assign step_iter     = iter_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign best_len      = best_len_q;
  assign best_len_num  = best_len_num_q;
  assign best_peak     = best_peak_q;
  assign best_peak_num = best_peak_num_q;
  assign fail_count    = fail_count_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Randomized bench for collatz_sweep_ctrl against an arithmetic sweep model,
// with a behavioural Collatz step unit attached to the step interface.
module tb_collatz_sweep_ctrl;

  localparam int unsigned BITS      = 16;
  localparam int unsigned CNT_BITS  = 8;
  localparam int unsigned LEN_BITS  = 8;
  localparam int unsigned MAX_STEPS = 100;
  localparam int unsigned WW        = BITS + 2;
  localparam longint      MAXV      = (longint'(1) << BITS) - 1;

  typedef struct {
    longint blen;
    longint blen_num;
    longint bpeak;
    longint bpeak_num;
    longint fails;
    longint total;
    bit     aborted;
    bit     done;
    int     busy;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [BITS-1:0]     base = '0;
  logic [CNT_BITS-1:0] count = '0;
  logic [BITS-1:0]     step_iter;
  logic [BITS-1:0]     step_next;
  logic                step_ovf;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [LEN_BITS-1:0] best_len;
  logic [BITS-1:0]     best_len_num;
  logic [BITS-1:0]     best_peak;
  logic [BITS-1:0]     best_peak_num;
  logic [CNT_BITS-1:0] fail_count;
  logic [47:0]         total_steps;

  int n_checks = 0;
  int n_errors = 0;

  collatz_sweep_ctrl #(
    .BITS(BITS), .CNT_BITS(CNT_BITS), .LEN_BITS(LEN_BITS), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base(base), .count(count),
    .step_iter(step_iter), .step_next(step_next), .step_ovf(step_ovf),
    .busy(busy), .done(done), .aborted(aborted),
    .best_len(best_len), .best_len_num(best_len_num),
    .best_peak(best_peak), .best_peak_num(best_peak_num),
    .fail_count(fail_count), .total_steps(total_steps)
  );

  always #5 clk = ~clk;

  // External step unit: n/2 or 3n+1 with overflow flag
  logic [WW-1:0] step_wide;
  always_comb begin
    if (step_iter[0]) step_wide = ({2'b00, step_iter} << 1) + {2'b00, step_iter} + WW'(1);
    else              step_wide = {3'b000, step_iter[BITS-1:1]};
  end
  assign step_next = step_wide[BITS-1:0];
  assign step_ovf  = |step_wide[WW-1:BITS];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Orbit of one start value under the sweep rules
  function automatic void orbit(input longint n0, output int steps, output longint pk, output bit ok);
    longint n;
    n = n0; steps = 0; pk = n0; ok = 1'b0;
    while (1) begin
      if (n == 1) begin ok = 1'b1; break; end
      if (n == 0 || steps == int'(MAX_STEPS)) break;
      if (n % 2 == 0) n = n / 2;
      else begin
        if (3 * n + 1 > MAXV) break;
        n = 3 * n + 1;
      end
      steps++;
      if (n > pk) pk = n;
    end
  endfunction

  // Whole-sweep expectation; ak is the busy-cycle index holding abort (-1 = none)
  function automatic exp_t model_sweep(input longint b, input int cnt, input int ak);
    exp_t   e;
    longint cur, pk;
    int     rem, t, len, rec_t, part;
    bit     ok;
    e = '{default: 0};
    if (cnt == 0) begin
      e.done = 1'b1;
      return e;
    end
    cur = b; rem = cnt; t = 0;
    while (1) begin
      orbit(cur, len, pk, ok);
      rec_t = t + len + 2;
      if (ak >= 0 && ak <= rec_t) begin
        part = ak - (t + 1);
        if (part < 0) part = 0;
        if (part > len) part = len;
        e.total += longint'(part);
        e.aborted = 1'b1;
        e.busy = ak + 1;
        break;
      end
      e.total += longint'(len);
      if (ok) begin
        if (longint'(len) > e.blen) begin e.blen = longint'(len); e.blen_num = cur; end
        if (pk > e.bpeak) begin e.bpeak = pk; e.bpeak_num = cur; end
      end else begin
        e.fails++;
      end
      t = rec_t + 1;
      if (rem == 1) begin e.done = 1'b1; e.busy = t; break; end
      if (cur == MAXV) begin e.aborted = 1'b1; e.busy = t; break; end
      cur++; rem--;
    end
    return e;
  endfunction

  task automatic check_results(input string tag, input exp_t e);
    check({tag, "_aborted"}, 64'(aborted), longint'(e.aborted));
    check({tag, "_best_len"}, 64'(best_len), e.blen);
    check({tag, "_best_len_num"}, 64'(best_len_num), e.blen_num);
    check({tag, "_best_peak"}, 64'(best_peak), e.bpeak);
    check({tag, "_best_peak_num"}, 64'(best_peak_num), e.bpeak_num);
    check({tag, "_fail_count"}, 64'(fail_count), e.fails);
`ifdef COLLATZ_TOTAL_STEPS_EN
    check({tag, "_total_steps"}, 64'(total_steps), e.total);
`else
    check({tag, "_total_steps"}, 64'(total_steps), 0);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_aborted"}, 64'(aborted), 0);
    check({tag, "_best_len"}, 64'(best_len), 0);
    check({tag, "_best_len_num"}, 64'(best_len_num), 0);
    check({tag, "_best_peak"}, 64'(best_peak), 0);
    check({tag, "_best_peak_num"}, 64'(best_peak_num), 0);
    check({tag, "_fail_count"}, 64'(fail_count), 0);
    check({tag, "_total_steps"}, 64'(total_steps), 0);
    check({tag, "_step_iter"}, 64'(step_iter), 0);
  endtask

  // One sweep: ak = busy cycle carrying abort, gk = busy cycle carrying a stray start
  task automatic run_sweep(input string tag, input longint b, input int cnt, input int ak,
                           input int gk, output exp_t e, output int busy_obs);
    bit fin;
    e = model_sweep(b, cnt, ak);
    @(negedge clk);
    base = BITS'(b); count = CNT_BITS'(cnt); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_obs = 0; fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin fin = 1'b1; break; end
      busy_obs++;
      abort = (i == ak);
      start = (i == gk);
      base  = BITS'($urandom);
      count = CNT_BITS'($urandom);
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    check({tag, "_finished"}, longint'(fin), 1);
    check({tag, "_busy_cycles"}, longint'(busy_obs), longint'(e.busy));
    check({tag, "_done"}, 64'(done), longint'(e.done));
    check_results(tag, e);
    @(negedge clk);
    check({tag, "_done_after"}, 64'(done), 0);
    check({tag, "_busy_after"}, 64'(busy), 0);
    check_results({tag, "_hold"}, e);
  endtask

  initial begin
    exp_t e;
    int   bo;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_sweep("six", 6, 1, -1, -1, e, bo);
    check("six_busy_lit", longint'(bo), 11);
    check("six_len_lit", 64'(best_len), 8);
    check("six_peak_lit", 64'(best_peak), 16);
    check("six_len_num_lit", 64'(best_len_num), 6);
    check("six_peak_num_lit", 64'(best_peak_num), 6);

    run_sweep("one_ten", 1, 10, -1, 5, e, bo);
    check("one_ten_len_lit", 64'(best_len), 19);
    check("one_ten_len_num_lit", 64'(best_len_num), 9);
    check("one_ten_peak_lit", 64'(best_peak), 52);
    check("one_ten_peak_num_lit", 64'(best_peak_num), 7);
    check("one_ten_fail_lit", 64'(fail_count), 0);
`ifdef COLLATZ_TOTAL_STEPS_EN
    check("one_ten_total_lit", 64'(total_steps), 67);
`endif

    run_sweep("n27", 27, 1, -1, -1, e, bo);
    check("n27_fail_lit", 64'(fail_count), 1);
    check("n27_len_lit", 64'(best_len), 0);
    check("n27_peak_lit", 64'(best_peak), 0);

    run_sweep("wrap", MAXV, 3, -1, -1, e, bo);
    check("wrap_fail_lit", 64'(fail_count), 1);
    check("wrap_aborted_lit", 64'(aborted), 1);
    check("wrap_done_lit", 64'(done), 0);

    run_sweep("abort7", 7, 5, 10, -1, e, bo);
    check("abort7_aborted_lit", 64'(aborted), 1);
    check("abort7_len_lit", 64'(best_len), 0);
    check("abort7_peak_lit", 64'(best_peak), 0);

    run_sweep("zero_cnt", 100, 0, 0, -1, e, bo);
    check("zero_cnt_aborted_lit", 64'(aborted), 0);

    for (int r = 0; r < 25; r++) begin
      longint b;
      int     cnt, ak, gk, sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = MAXV - longint'($urandom_range(0, 5));
      else if (sel == 1) b = longint'($urandom_range(0, 3));
      else               b = longint'($urandom_range(1, 3000));
      cnt = int'($urandom_range(0, 6));
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 250)) : -1;
      gk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
      run_sweep($sformatf("rnd%0d", r), b, cnt, ak, gk, e, bo);
    end

    // Asynchronous reset in the middle of a sweep
    @(negedge clk);
    base = BITS'(1); count = CNT_BITS'(10); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_pre_busy", 64'(busy), 1);
    check("midrst_pre_best_len", 64'(best_len), 7);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_busy", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
